// File: rtl/ysyx_220066_trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM states, interrupt cause
// codes and the bit positions of the machine interrupt-pending register.
package ysyx_220066_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_TRAP   = 2'd2,
    ST_SETTLE = 2'd3
  } trap_state_e;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  // mcause for an interrupt: top bit flags "interrupt", low nibble is the code
  function automatic logic [63:0] irq_cause(input logic [3:0] code);
    return {1'b1, 59'b0, code};
  endfunction

endpackage

// File: rtl/ysyx_220066_mtimer.sv
// Machine timer: free-running mtime with a writable compare register.
// mtip is derived from registered values only, so it never sees a same-cycle write.
module ysyx_220066_mtimer (
  input  logic        clk,
  input  logic        rst,
  input  logic        tw_en_i,
  input  logic        tw_sel_i,
  input  logic [63:0] tw_data_i,
  output logic [63:0] mtime_o,
  output logic        mtip_o
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;

  // A software write to mtime overrides that cycle's increment
  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (tw_en_i) begin
      if (tw_sel_i) mtimecmp_d = tw_data_i;
      else          mtime_d    = tw_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  assign mtime_o = mtime_q;
  assign mtip_o  = (mtime_q >= mtimecmp_q);

endmodule

// File: rtl/ysyx_220066_trap_ctrl.sv
// Trap controller: arbitrates commit-stage exceptions against enabled interrupts,
// drains the pipeline, then pulses raise_intr with a stable mcause/mepc.
module ysyx_220066_trap_ctrl
  import ysyx_220066_trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_code,
  input  logic [63:0] exc_pc,
  input  logic        commit_valid,
  input  logic [63:0] commit_pc,
  input  logic        mstatus_mie,
  input  logic [63:0] mie,
  input  logic        irq_sw,
  input  logic        irq_ext,
  input  logic        tw_en,
  input  logic        tw_sel,
  input  logic [63:0] tw_data,
  output logic        flush_req,
  input  logic        flush_ack,
  output logic        raise_intr,
  output logic [63:0] NO,
  output logic [63:0] pc,
  output logic        busy,
  output logic [63:0] mip,
  output logic [63:0] mtime
);

  trap_state_e state_q;
  logic        mtip;
  logic [63:0] pend;
  logic        irq_take;
  logic [3:0]  irq_code;

  ysyx_220066_mtimer u_mtimer (
    .clk       (clk),
    .rst       (rst),
    .tw_en_i   (tw_en),
    .tw_sel_i  (tw_sel),
    .tw_data_i (tw_data),
    .mtime_o   (mtime),
    .mtip_o    (mtip)
  );

  always_comb begin
    mip           = '0;
    mip[MIP_MEIP] = irq_ext;
    mip[MIP_MTIP] = mtip;
    mip[MIP_MSIP] = irq_sw;
  end

  assign pend     = mip & mie;
  assign irq_take = commit_valid & mstatus_mie & (|pend);

  // Fixed priority MEI > MSI > MTI; only meaningful when irq_take is set
  always_comb begin
    irq_code = CAUSE_MTI;
    if (pend[MIP_MEIP])      irq_code = CAUSE_MEI;
    else if (pend[MIP_MSIP]) irq_code = CAUSE_MSI;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      flush_req  <= 1'b0;
      raise_intr <= 1'b0;
      busy       <= 1'b0;
      NO         <= '0;
      pc         <= '0;
    end else begin
      raise_intr <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (exc_valid) begin
            NO        <= {60'b0, exc_code};
            pc        <= exc_pc;
            flush_req <= 1'b1;
            busy      <= 1'b1;
            state_q   <= ST_DRAIN;
          end else if (irq_take) begin
            NO        <= irq_cause(irq_code);
            pc        <= commit_pc;
            flush_req <= 1'b1;
            busy      <= 1'b1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (flush_ack) begin
            flush_req  <= 1'b0;
            raise_intr <= 1'b1;
            state_q    <= ST_TRAP;
          end
        end
        // SETTLE gives the CSR file a cycle to update mstatus before re-arbitration
        ST_TRAP:   state_q <= ST_SETTLE;
        ST_SETTLE: begin
          busy    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_220066_trap_ctrl.sv
// Bench for the trap controller: expected mcause/mepc pairs go into a scoreboard
// queue at acceptance, and an independent monitor pops them on every raise_intr.
module tb_ysyx_220066_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [63:0] exc_pc;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic        mstatus_mie;
  logic [63:0] mie;
  logic        irq_sw, irq_ext;
  logic        tw_en, tw_sel;
  logic [63:0] tw_data;
  logic        flush_req, flush_ack;
  logic        raise_intr;
  logic [63:0] NO, pc;
  logic        busy;
  logic [63:0] mip, mtime;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] no;
    logic [63:0] pc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  ysyx_220066_trap_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .mstatus_mie(mstatus_mie), .mie(mie),
    .irq_sw(irq_sw), .irq_ext(irq_ext),
    .tw_en(tw_en), .tw_sel(tw_sel), .tw_data(tw_data),
    .flush_req(flush_req), .flush_ack(flush_ack),
    .raise_intr(raise_intr), .NO(NO), .pc(pc),
    .busy(busy), .mip(mip), .mtime(mtime)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every raise_intr pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && raise_intr === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL raise_unexpected: got raise_intr=1 NO=%h pc=%h expected no trap", NO, pc);
        end else begin
          mon_e = sbq.pop_front();
          chk("mcause", NO, mon_e.no);
          chk("mepc", pc, mon_e.pc);
        end
      end
    end
  end

  // Reference: exception first, then the highest-priority enabled pending interrupt
  function automatic bit ref_trap(input bit ev, input logic [3:0] ec, input logic [63:0] epc,
                                  input bit cv, input logic [63:0] cpc, input bit gie,
                                  input logic [63:0] miev, input bit sw, input bit ext,
                                  input bit tip, output logic [63:0] no, output logic [63:0] p);
    int          order[3];
    logic [63:0] pend;
    order = '{11, 3, 7};
    no = '0;
    p  = '0;
    if (ev) begin
      no = {60'd0, ec};
      p  = epc;
      return 1'b1;
    end
    pend = (64'(ext) << 11) | (64'(tip) << 7) | (64'(sw) << 3);
    pend = pend & miev;
    if (cv && gie) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[order[i]]) begin
          no = 64'h8000_0000_0000_0000 | 64'(order[i]);
          p  = cpc;
          return 1'b1;
        end
      end
    end
    return 1'b0;
  endfunction

  task automatic clear_in();
    exc_valid = 0; exc_code = 0; exc_pc = 0;
    commit_valid = 0; commit_pc = 0;
    mstatus_mie = 0; mie = 0; irq_sw = 0; irq_ext = 0;
    tw_en = 0; tw_sel = 0; tw_data = 0; flush_ack = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // All tasks start and end one time unit after a rising edge
  task automatic write_cmp(input logic [63:0] v);
    tw_en = 1; tw_sel = 1; tw_data = v;
    @(posedge clk); #1;
    tw_en = 0; tw_sel = 0; tw_data = 0;
  endtask

  task automatic post_accept(input bit exp, input logic [63:0] eno, input logic [63:0] epc,
                             input int delay, input string tag);
    exp_t e;
    if (!exp) begin
      @(negedge clk);
      chk({tag, "_no_trap_busy"}, busy, 0);
      chk({tag, "_no_trap_flush"}, flush_req, 0);
      @(posedge clk); #1;
      return;
    end
    e.no = eno;
    e.pc = epc;
    sbq.push_back(e);
    flush_ack = (delay == 0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_hold_flush_req"}, flush_req, 1);
      chk({tag, "_hold_raise"}, raise_intr, 0);
      @(posedge clk); #1;
      if (i == delay - 1) flush_ack = 1;
    end
    @(negedge clk);
    chk({tag, "_drain_flush_req"}, flush_req, 1);
    chk({tag, "_drain_busy"}, busy, 1);
    @(posedge clk); #1 flush_ack = 0;
    @(negedge clk);
    chk({tag, "_trap_raise"}, raise_intr, 1);
    chk({tag, "_trap_flush_req"}, flush_req, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_settle_raise"}, raise_intr, 0);
    chk({tag, "_settle_busy"}, busy, 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_hold_no"}, NO, eno);
    chk({tag, "_idle_hold_pc"}, pc, epc);
    @(posedge clk); #1;
  endtask

  // One presentation cycle; tip is forced through mtimecmp (0 -> pending, max -> not)
  task automatic trial(input bit ev, input logic [3:0] ec, input logic [63:0] epc,
                       input bit cv, input logic [63:0] cpc, input bit gie,
                       input logic [63:0] miev, input bit sw, input bit ext, input bit tip,
                       input int delay, input string tag);
    logic [63:0] eno, ep;
    bit          exp;
    write_cmp(tip ? 64'd0 : 64'hFFFF_FFFF_FFFF_FFFF);
    exp = ref_trap(ev, ec, epc, cv, cpc, gie, miev, sw, ext, tip, eno, ep);
    exc_valid = ev; exc_code = ec; exc_pc = epc;
    commit_valid = cv; commit_pc = cpc; mstatus_mie = gie; mie = miev;
    irq_sw = sw; irq_ext = ext;
    #1 chk({tag, "_mip"}, mip, (64'(ext) << 11) | (64'(tip) << 7) | (64'(sw) << 3));
    @(posedge clk); #1;
    clear_in();
    post_accept(exp, eno, ep, delay, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    bit          got;
    logic [63:0] all3;
    all3 = 64'h888;

    // Reset state
    rst = 1'b1;
    clear_in();
    #3;
    chk("rst_flush_req", flush_req, 0);
    chk("rst_raise", raise_intr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_no", NO, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mtime", mtime, 0);
    chk("rst_mip", mip, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Exception with flush already acknowledged: minimum latency
    trial(1, 4'd11, 64'h8000_0010, 0, 0, 0, 0, 0, 0, 0, 0, "exc_min");

    // Timer interrupt once mtime reaches mtimecmp=20
    do_reset();
    write_cmp(64'd20);
    mie = 64'h80; mstatus_mie = 1; commit_valid = 1; commit_pc = 64'h8000_0100;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (busy) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL mti_timeout: got busy=0 expected timer trap within 60 cycles");
    end else begin
      clear_in();
      chk("mti_accept_mtime", mtime, 64'd21);
      post_accept(1, 64'h8000_0000_0000_0007, 64'h8000_0100, 0, "mti");
    end

    // Priority and exception-over-interrupt
    trial(0, 0, 0, 1, 64'h8000_0200, 1, all3, 1, 1, 1, 1, "prio_mei");
    trial(0, 0, 0, 1, 64'h8000_0204, 1, all3, 1, 0, 1, 0, "prio_msi");
    trial(1, 4'd2, 64'h8000_0300, 1, 64'h8000_0304, 1, all3, 1, 1, 1, 0, "exc_wins");

    // Global disable blocks interrupts but not exceptions
    trial(0, 0, 0, 1, 64'h8000_0400, 0, all3, 0, 1, 0, 0, "mie_off_irq");
    trial(1, 4'd2, 64'h8000_0404, 1, 64'h8000_0408, 0, all3, 0, 1, 0, 0, "mie_off_exc");

    // Long drain; IRQ line has already dropped after acceptance
    trial(0, 0, 0, 1, 64'h8000_0500, 1, all3, 0, 1, 0, 5, "long_drain");

    // Randomized presentations
    for (int n = 0; n < 40; n++) begin
      trial(($urandom % 4) == 0, 4'($urandom), {$urandom, $urandom},
            ($urandom % 4) != 0, {$urandom, $urandom}, ($urandom % 4) != 0,
            {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "rand");
    end

    // Reset in the middle of DRAIN takes effect without a clock edge
    exc_valid = 1; exc_code = 4'd5; exc_pc = 64'h8000_0600;
    @(posedge clk); #1 clear_in();
    @(negedge clk);
    chk("mid_drain_flush_req", flush_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_flush_req", flush_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_no", NO, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_mtime", mtime, 0);
    @(posedge clk); #1 rst = 1'b0;

    // mtime write beats the increment, then counting resumes and wraps
    tw_en = 1; tw_sel = 0; tw_data = 64'h1234_5678_9ABC_DEF0;
    @(posedge clk); #1 tw_en = 0;
    chk("mtime_write", mtime, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    chk("mtime_inc", mtime, 64'h1234_5678_9ABC_DEF1);
    tw_en = 1; tw_sel = 0; tw_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1 tw_en = 0;
    chk("mtime_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    chk("mtime_wrap", mtime, 64'd0);

    repeat (3) @(posedge clk);
    chk("sb_drained", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_trap_ctrl.md
YSYX_220066_TRAP_CTRL -- requirements
Module: ysyx_220066_trap_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: exc_valid  in  1  synchronous exception at commit stage; exc_code  in  4  exception cause; exc_pc  in  64  faulting PC.
REQ-004 SHALL have ports: commit_valid  in  1  an instruction is about to commit; commit_pc  in  64  its PC, which is the interrupt EPC.
REQ-005 SHALL have ports: mstatus_mie  in  1  global enable, mstatus[3] from the CSR file; mie  in  64  mie CSR, bits 3/7/11 used.
REQ-006 SHALL have ports: irq_sw  in  1  software IRQ level; irq_ext  in  1  external IRQ level.
REQ-007 SHALL have ports: tw_en  in  1  timer register write; tw_sel  in  1  target, 0=mtime, 1=mtimecmp; tw_data  in  64  write data.
REQ-008 SHALL have ports: flush_req  out  1  pipeline drain request; flush_ack  in  1  pipeline drained.
REQ-009 SHALL have ports: raise_intr  out  1  one-cycle trap pulse to the CSR file; NO  out  64  mcause value; pc  out  64  mepc value.
REQ-010 SHALL have ports: busy  out  1  a trap is in flight; mip  out  64  pending bits; mtime  out  64  timer value.

Function
REQ-011 mtime SHALL increment by 1 every cycle, wrapping at 2^64-1 to 0; a tw_en write with tw_sel=0 SHALL take priority over the increment in that cycle.
REQ-012 mtip SHALL equal (mtime >= mtimecmp), compared unsigned, using registered values; mip SHALL be {52'b0, irq_ext, 3'b0, mtip, 3'b0, irq_sw, 3'b0} (bit 11 MEIP, bit 7 MTIP, bit 3 MSIP).
REQ-013 State machine SHALL have states IDLE, DRAIN, TRAP and SETTLE.
REQ-014 In IDLE, exc_valid=1 SHALL latch NO={60'b0,exc_code} and pc=exc_pc, then go to DRAIN; exceptions SHALL be accepted regardless of mstatus_mie.
REQ-015 In IDLE with exc_valid=0, commit_valid=1, mstatus_mie=1 and (mip&mie)!=0, the block SHALL latch an interrupt cause and pc=commit_pc, then go to DRAIN.
REQ-016 Interrupt cause priority SHALL be MEI(11) > MSI(3) > MTI(7); NO SHALL be {1'b1,59'b0,code}.
REQ-017 Exceptions SHALL win over interrupts presented in the same cycle.
REQ-018 In DRAIN, flush_req SHALL be 1; the block SHALL stay in DRAIN until flush_ack=1, then go to TRAP the next cycle.
REQ-019 In TRAP, raise_intr SHALL be 1 for exactly one cycle, with NO and pc stable; the next state SHALL be SETTLE.
REQ-020 SETTLE SHALL last one cycle so the CSR file can update mstatus; the block SHALL then return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Once latched, the cause SHALL be committed even if the IRQ line or enable drops during DRAIN.
REQ-023 exc_valid and IRQs SHALL be ignored outside IDLE; the pipeline holds exc_valid until busy falls.
REQ-024 Minimum latency from acceptance to raise_intr SHALL be 2 cycles (flush_ack already 1).
REQ-025 NO and pc SHALL hold their last latched values in IDLE.

Reset
REQ-026 Asserting rst at any time, including mid-trap, SHALL force: state=IDLE; flush_req=0; raise_intr=0; busy=0; NO=0; pc=0; mtime=0; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.

Structure
REQ-027 State encodings, cause codes (MSI=3, MTI=7, MEI=11) and mip bit positions SHALL live in a shared package.
REQ-028 The timer (mtime, mtimecmp, write port, mtip compare) SHALL be a sub-module named ysyx_220066_mtimer; arbitration and the FSM SHALL stay in the top module.

Verification
REQ-029 Bench SHALL check: exc_valid=1, exc_code=11, exc_pc=0x8000_0010, flush_ack=1 -> raise_intr=1 two cycles later, NO=0xB, pc=0x8000_0010, busy low after SETTLE.
REQ-030 Bench SHALL check: mtimecmp=20, mie[7]=1, mstatus_mie=1, commit_valid=1 with commit_pc=0x8000_0100 -> NO=0x8000_0000_0000_0007 after mtime reaches 20.
REQ-031 Bench SHALL check: irq_ext=irq_sw=1, mtip=1, all enabled -> NO=0x8000_0000_0000_000B; with exc_valid=1 (code 2) in the same cycle -> NO=2.
REQ-032 Bench SHALL check: mstatus_mie=0 with irq_ext=1 -> no trap; exc_valid=1 (code 2) -> trap still taken.
REQ-033 Bench SHALL check: flush_ack held 0 for 5 cycles while in DRAIN -> flush_req stays high; irq dropping meanwhile -> raise_intr still pulses once.
REQ-034 Bench SHALL check: rst asserted in DRAIN -> flush_req=0 and busy=0 immediately; tw_en write to mtime concurrent with increment -> written value.
